// File: rtl/pipe_memwrt_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : pipe_memwrt_gen                                          |
// | Description : Memory / write-back pipeline stage. Registers one        |
// |               instruction from execute, runs the data-memory req/ack   |
// |               handshake, holds condition flags and resolves the        |
// |               delayed branch.                                          |
// | Revision    : 1.0 - initial parametrised release                       |
// +------------------------------------------------------------------------+
module pipe_memwrt_gen #(
  parameter int DW       = 16,
  parameter int AW       = 9,
  parameter int CW       = 22,
  parameter int FLAG_BIT = 8,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] control_in,
  input  logic [5:0]    inst_type_in,
  input  logic [DW-1:0] result_in,
  input  logic [DW-1:0] data_Rd_in,
  input  logic          hi_Rm_in,
  input  logic          hi_Rn_in,
  input  logic [DW-1:0] delayed_B_in,
  input  logic [2:0]    delayed_cond_in,
  input  logic          N_in,
  input  logic          V_in,
  input  logic          Z_in,
  input  logic          kill_in,
  output logic          out_valid,
  output logic [DW-1:0] result_out,
  output logic [CW-1:0] control_out,
  output logic [5:0]    inst_type_out,
  output logic          N_out,
  output logic          Z_out,
  output logic          V_out,
  output logic [DW-1:0] delayed_B_out,
  output logic          do_delayed_B,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          mem_err
);

  localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_MEM   = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  logic                r_killed, w_killed_next;
  logic [CW-1:0]       r_control;
  logic [5:0]          r_inst_type;
  logic [DW-1:0]       r_result;
  logic [DW-1:0]       r_data_rd;
  logic [DW-1:0]       r_delayed_b;
  logic [2:0]          r_cond;
  logic [DW+1:0]       r_flag;
  logic [c_WAIT_W-1:0] r_wait;
  logic                r_mem_err;

  logic w_accept;
  logic w_in_is_mem;
  logic w_timeout;
  logic w_lt;

  assign in_ready    = (r_state != S_MEM);
  assign w_accept    = in_valid & in_ready;
  assign w_in_is_mem = inst_type_in[1] | inst_type_in[2];
  // Timeout only when neither ack nor kill already resolves this MEM cycle.
  assign w_timeout   = (r_state == S_MEM) & ~mem_ack & ~kill_in & (r_wait == c_WAIT_LAST);

  // Next state and "squashed on entry to DONE" marker.
  always_comb begin
    w_state_next  = r_state;
    w_killed_next = r_killed;
    case (r_state)
      S_MEM: begin
        if (mem_ack) begin
          w_state_next  = S_DONE;
          w_killed_next = kill_in;
        end else if (kill_in) begin
          w_state_next  = S_EMPTY;
        end else if (w_timeout) begin
          w_state_next  = S_DONE;
          w_killed_next = 1'b0;
        end
      end
      default: begin
        if (w_accept) begin
          w_state_next  = (w_in_is_mem && !kill_in) ? S_MEM : S_DONE;
          w_killed_next = kill_in;
        end else begin
          w_state_next  = S_EMPTY;
        end
      end
    endcase
  end

  // State, entry, flag, wait-counter and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_killed    <= 1'b0;
      r_control   <= '0;
      r_inst_type <= '0;
      r_result    <= '0;
      r_data_rd   <= '0;
      r_delayed_b <= '0;
      r_cond      <= '0;
      r_flag      <= '0;
      r_wait      <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_killed <= w_killed_next;
      if (w_accept) begin
        r_control   <= control_in;
        r_inst_type <= inst_type_in;
        r_result    <= result_in;
        r_data_rd   <= data_Rd_in;
        r_delayed_b <= delayed_B_in;
        r_cond      <= delayed_cond_in;
        if (control_in[FLAG_BIT]) begin
          r_flag <= {hi_Rm_in, hi_Rn_in, result_in};
        end
      end else if ((r_state == S_MEM) && mem_ack && r_inst_type[2]) begin
        r_result <= mem_rdata;
      end
      if ((r_state == S_MEM) && !mem_ack) begin
        r_wait <= r_wait + 1'b1;
      end else begin
        r_wait <= '0;
      end
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Memory port is driven straight from the held entry so it stays stable.
  always_comb begin
    mem_req   = (r_state == S_MEM);
    mem_we    = (r_state == S_MEM) & r_inst_type[1];
    mem_addr  = r_result[AW-1:0];
    mem_wdata = r_data_rd;
  end

  // Stage outputs, flags and delayed-branch target.
  always_comb begin
    out_valid                = (r_state == S_DONE) & ~r_killed;
    result_out               = r_result;
    control_out              = r_control;
    inst_type_out            = r_inst_type;
    mem_err                  = r_mem_err;
    N_out                    = r_flag[DW-1];
    Z_out                    = ~|r_flag[DW-1:0];
    V_out                    = (~r_flag[DW] &  r_flag[DW+1] &  r_flag[DW-1]) |
                               ( r_flag[DW] & ~r_flag[DW+1] & ~r_flag[DW-1]);
    delayed_B_out            = r_delayed_b;
    if (r_inst_type[3] || r_inst_type[4]) begin
      delayed_B_out[7:0] = r_data_rd[7:0];
    end
  end

  // Delayed-branch condition against the live resolved flags.
  always_comb begin
    w_lt         = N_in ^ V_in;
    do_delayed_B = 1'b0;
    case (r_cond)
      3'd0:    do_delayed_B = 1'b0;
      3'd1:    do_delayed_B = 1'b1;
      3'd2:    do_delayed_B = Z_in;
      3'd3:    do_delayed_B = ~Z_in;
      3'd4:    do_delayed_B = w_lt;
      3'd5:    do_delayed_B = w_lt | Z_in;
      3'd6:    do_delayed_B = ~(w_lt | Z_in);
      default: do_delayed_B = ~w_lt;
    endcase
    if (r_state == S_EMPTY) begin
      do_delayed_B = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_memwrt_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_pipe_memwrt_gen                                       |
// | Description : Self-checking bench for pipe_memwrt_gen: directed cases  |
// |               followed by randomized transactions against a           |
// |               transaction-level reference model.                      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_pipe_memwrt_gen;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int CW = 22;
  localparam int FB = 8;
  localparam int MW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] control_in = '0;
  logic [5:0]    inst_type_in = '0;
  logic [DW-1:0] result_in = '0;
  logic [DW-1:0] data_Rd_in = '0;
  logic          hi_Rm_in = 1'b0;
  logic          hi_Rn_in = 1'b0;
  logic [DW-1:0] delayed_B_in = '0;
  logic [2:0]    delayed_cond_in = '0;
  logic          N_in = 1'b0;
  logic          V_in = 1'b0;
  logic          Z_in = 1'b0;
  logic          kill_in = 1'b0;
  logic          out_valid;
  logic [DW-1:0] result_out;
  logic [CW-1:0] control_out;
  logic [5:0]    inst_type_out;
  logic          N_out, Z_out, V_out;
  logic [DW-1:0] delayed_B_out;
  logic          do_delayed_B;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          mem_err;

  pipe_memwrt_gen #(.DW(DW), .AW(AW), .CW(CW), .FLAG_BIT(FB), .MAX_WAIT(MW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .control_in(control_in), .inst_type_in(inst_type_in), .result_in(result_in),
    .data_Rd_in(data_Rd_in), .hi_Rm_in(hi_Rm_in), .hi_Rn_in(hi_Rn_in),
    .delayed_B_in(delayed_B_in), .delayed_cond_in(delayed_cond_in),
    .N_in(N_in), .V_in(V_in), .Z_in(Z_in), .kill_in(kill_in),
    .out_valid(out_valid), .result_out(result_out), .control_out(control_out),
    .inst_type_out(inst_type_out), .N_out(N_out), .Z_out(Z_out), .V_out(V_out),
    .delayed_B_out(delayed_B_out), .do_delayed_B(do_delayed_B),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: last loaded flag word {hi_Rm, hi_Rn, result} and sticky error.
  logic [DW+1:0] m_flag = '0;
  bit            m_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Branch decision from the condition table, using signed-compare meaning.
  function automatic bit branch_taken(input logic [2:0] cond, input logic n, v, z);
    bit lt = (n != v);
    case (cond)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return lt;
      3'd5: return lt || z;
      3'd6: return !(lt || z);
      default: return !lt;
    endcase
  endfunction

  // One instruction from offer to completion. wcyc = MEM cycle index carrying ack
  // (>= MW means never), kill_at = MEM cycle index where kill arrives (-1 none).
  task automatic run_txn(input logic [5:0] typ, input logic [CW-1:0] ctl,
                         input logic [DW-1:0] res, input logic [DW-1:0] rd,
                         input logic [DW-1:0] db, input logic [2:0] cond,
                         input logic hm, input logic hn, input logic kill,
                         input int wcyc, input int kill_at, input logic [DW-1:0] rdata,
                         input logic [2:0] nvz, input bit idle);
    logic [DW-1:0] exp_res;
    logic [DW-1:0] exp_db;
    logic          fn;
    check("in_ready_offer", in_ready, 1);
    inst_type_in = typ; control_in = ctl; result_in = res; data_Rd_in = rd;
    delayed_B_in = db; delayed_cond_in = cond; hi_Rm_in = hm; hi_Rn_in = hn;
    in_valid = 1'b1; kill_in = kill;
    tick();
    in_valid = 1'b0; kill_in = 1'b0;
    if (ctl[FB]) m_flag = {hm, hn, res};
    exp_res = res;
    if ((typ[1] || typ[2]) && !kill) begin
      for (int c = 0; c < MW; c++) begin
        check("mem_req", mem_req, 1);
        check("mem_we", mem_we, typ[1]);
        check("mem_addr", mem_addr, res[AW-1:0]);
        check("mem_wdata", mem_wdata, rd);
        check("in_ready_mem", in_ready, 0);
        if (c == kill_at) begin
          kill_in = 1'b1;
          tick();
          kill_in = 1'b0;
          check("kill_mem_req", mem_req, 0);
          check("kill_mem_valid", out_valid, 0);
          check("kill_mem_ready", in_ready, 1);
          return;
        end
        if (c == wcyc) begin
          mem_ack = 1'b1; mem_rdata = rdata;
          tick();
          mem_ack = 1'b0;
          if (typ[2]) exp_res = rdata;
          break;
        end
        tick();
        if (c == MW - 1) m_err = 1'b1;
      end
    end
    {N_in, V_in, Z_in} = nvz;
    #1;
    fn = m_flag[DW-1];
    exp_db = ((typ[3] || typ[4]) ? {db[DW-1:8], rd[7:0]} : db);
    check("out_valid", out_valid, !kill);
    check("done_mem_req", mem_req, 0);
    check("done_ready", in_ready, 1);
    check("result_out", result_out, exp_res);
    check("control_out", control_out, ctl);
    check("inst_type_out", inst_type_out, typ);
    check("N_out", N_out, fn);
    check("Z_out", Z_out, (m_flag[DW-1:0] == '0));
    check("V_out", V_out, (m_flag[DW] != m_flag[DW+1]) && (fn == m_flag[DW+1]));
    check("delayed_B_out", delayed_B_out, exp_db);
    check("do_delayed_B", do_delayed_B, branch_taken(cond, nvz[2], nvz[1], nvz[0]));
    check("mem_err", mem_err, m_err);
    if (idle) begin
      tick();
      check("idle_valid", out_valid, 0);
      check("idle_branch", do_delayed_B, 0);
      check("idle_ready", in_ready, 1);
    end
  endtask

  initial begin
    logic [5:0] typ;
    int         w, ka;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_branch", do_delayed_B, 0);
    check("rst_ready", in_ready, 1);
    check("rst_N", N_out, 0);
    check("rst_Z", Z_out, 1);
    check("rst_V", V_out, 0);
    check("rst_err", mem_err, 0);

    // Back-to-back ALU stream with flag load.
    run_txn(6'b000001, 22'h100, 16'h0005, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, -1, 16'h0, 3'b000, 0);
    run_txn(6'b000001, 22'h100, 16'h0000, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, -1, 16'h0, 3'b000, 0);
    run_txn(6'b000001, 22'h100, 16'h8000, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, -1, 16'h0, 3'b000, 1);
    // Store with two wait cycles, zero-wait load, killed store.
    run_txn(6'b000010, 22'h0, 16'h01A4, 16'hBEEF, 16'h0, 3'd0, 0, 0, 0, 2, -1, 16'h0, 3'b000, 1);
    run_txn(6'b000100, 22'h0, 16'h0033, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, -1, 16'h1234, 3'b000, 1);
    run_txn(6'b000010, 22'h0, 16'h0044, 16'h5555, 16'h0, 3'd0, 0, 0, 1, 0, -1, 16'h0, 3'b000, 1);
    // Branch conditions and BX target splice.
    run_txn(6'b000001, 22'h0, 16'h0001, 16'h0, 16'h1000, 3'd4, 0, 0, 0, 0, -1, 16'h0, 3'b100, 1);
    run_txn(6'b001000, 22'h0, 16'h0001, 16'h00C3, 16'h4400, 3'd1, 0, 0, 0, 0, -1, 16'h0, 3'b000, 1);
    run_txn(6'b000001, 22'h0, 16'h0001, 16'h0, 16'h0, 3'd0, 0, 0, 0, 0, -1, 16'h0, 3'b111, 1);
    // Overflow flag, then ack timeout.
    run_txn(6'b000001, 22'h100, 16'h8001, 16'h0, 16'h0, 3'd0, 1, 0, 0, 0, -1, 16'h0, 3'b000, 1);
    run_txn(6'b000010, 22'h0, 16'h0077, 16'h1111, 16'h0, 3'd0, 0, 0, 0, MW, -1, 16'h0, 3'b000, 1);

    for (int i = 0; i < 150; i++) begin
      typ = 6'(1 << $urandom_range(0, 5));
      w   = $urandom_range(0, MW + 1);
      ka  = (($urandom % 6 == 0) && (w > 0)) ? $urandom_range(0, w - 1) : -1;
      run_txn(typ, CW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
              3'($urandom), 1'($urandom), 1'($urandom), ($urandom % 8 == 0),
              w, ka, DW'($urandom), 3'($urandom), 1'($urandom));
    end

    // Reset in the middle of a memory wait.
    inst_type_in = 6'b000010; control_in = '0; result_in = 16'h0010; data_Rd_in = 16'hAAAA;
    in_valid = 1'b1; kill_in = 1'b0;
    tick();
    in_valid = 1'b0;
    check("pre_rst_req", mem_req, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_we", mem_we, 0);
    check("mid_rst_err", mem_err, 0);
    check("mid_rst_valid", out_valid, 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_memwrt_gen.md
# pipe_memwrt_gen

Parametrised memory/write-back pipeline stage, the successor to the fixed 16-bit stage. It registers one instruction from execute and drives the data-memory port with a req/ack handshake, so multi-cycle RAM stalls upstream. It also holds the condition flags and resolves the delayed branch. Width, address range, control width and wait-timeout are generic, and loads return memory data on the stage output.

## Interface
Parameters:
- DW, 16, data/result width (≥8)
- AW, 9, memory address width (≤DW); address = result[AW-1:0]
- CW, 22, control bus width
- FLAG_BIT, 8, index of control bit that enables flag update
- MAX_WAIT, 15, ack timeout in cycles (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  execute offers an instruction
- in_ready  out  1  stage accepts this cycle
- control_in  in  CW  control word
- inst_type_in  in  6  one-hot: [0] ALU, [1] STR, [2] LDR, [3] BX, [4] BLX, [5] other
- result_in  in  DW  ALU result / effective address
- data_Rd_in  in  DW  store data / branch target register
- hi_Rm_in, hi_Rn_in  in  1 each  sign bits of shifted Rm and Rn
- delayed_B_in  in  DW  delayed branch target
- delayed_cond_in  in  3  NV=0 AL=1 EQ=2 NE=3 LT=4 LE=5 GT=6 GE=7
- N_in, V_in, Z_in  in  1 each  resolved flags used for branch condition
- kill_in  in  1  next-stage branch taken: current entry squashed
- out_valid  out  1  completed entry presented this cycle
- result_out  out  DW  ALU result, or load data for LDR
- control_out  out  CW; inst_type_out  out  6
- N_out, Z_out, V_out  out  1 each  flags from flag register
- delayed_B_out  out  DW  branch target
- do_delayed_B  out  1  delayed branch taken
- mem_req, mem_we  out  1 each; mem_addr  out  AW; mem_wdata  out  DW
- mem_rdata  in  DW; mem_ack  in  1
- mem_err  out  1  sticky: ack timeout occurred

## Operation
- States: EMPTY, MEM, DONE. Entry register holds all *_in fields. Accept = in_valid & in_ready.
- in_ready = (state != MEM).
- Accept of LDR/STR with kill_in=0 → MEM. Other accepts → DONE. No accept → EMPTY.
- MEM: mem_req=1, mem_we=inst_type[1], mem_addr=result[AW-1:0], mem_wdata=data_Rd.
  - mem_ack → DONE; for LDR, result register ← mem_rdata.
  - kill_in while in MEM: if ack is also high this cycle the access completes; otherwise req drops next cycle and the entry is discarded → EMPTY with out_valid=0.
- Wait counter counts MEM cycles. Reaching MAX_WAIT sets mem_err (sticky until rst) and forces DONE. Result is unchanged and mem_we is never reasserted.
- DONE: out_valid=1 for exactly one cycle; out_valid=0 if kill_in was high on entering DONE. Back-to-back accept allowed.
- Flag register (DW+2 bits) loads {hi_Rm,hi_Rn,result_in} on accept when control_in[FLAG_BIT]=1.
  - N_out = flagres[DW-1]; Z_out = ~|flagres.
  - V_out = 1 iff {hi_Rn,hi_Rm,N} ∈ {011,100}.
- do_delayed_B is combinational from the registered cond and N_in/V_in/Z_in:
  - NV→0, AL→1, EQ→Z, NE→~Z, LT→N≠V, LE→(N≠V)|Z, GT→~LE, GE→N==V.
  - Forced 0 when state=EMPTY.
- delayed_B_out: upper DW-8 bits from the delayed_B register. Low 8 bits = data_Rd[7:0] if inst_type is BX or BLX, else delayed_B[7:0].

## Timing
- Reset: state EMPTY; control, inst_type, cond, flag registers and counter cleared; mem_err=0. Outputs: out_valid=0, mem_req=0, mem_we=0, do_delayed_B=0, in_ready=1, N=0, Z=1, V=0.
- Non-memory latency: accept at edge k → out_valid in cycle k+1.
- Memory latency: req in cycle k+1; ack at edge k+1+w → out_valid in cycle k+2+w.
- Zero-wait ack (ack in the first req cycle) is legal.
- mem_addr, mem_wdata and mem_we are stable while mem_req=1.
- rst during MEM drops mem_req on the next edge; no write completes after reset.

## Test plan
- ALU stream: 3 back-to-back ALU ops with result 0x0005, 0x0000, 0x8000 and flag-load set → out_valid each cycle; Z=0,1,0 and N=0,0,1 one cycle after each accept.
- STR: addr 0x01A4, Rd 0xBEEF, ack after 2 cycles → mem_req high 3 cycles, mem_addr=0x1A4, mem_wdata=0xBEEF, in_ready=0 during wait.
- LDR: mem_rdata=0x1234 with ack in the first cycle → result_out=0x1234, out_valid 2 cycles after accept.
- Kill: STR accepted with kill_in=1 → mem_req never asserted, out_valid=0.
- Branch: cond LT with N_in=1, V_in=0 → do_delayed_B=1; BX with Rd=0x00C3 and delayed_B=0x4400 → delayed_B_out=0x44C3; cond NV → 0.
- Overflow/timeout: Rn=+, Rm=−, result negative → V=1. No ack for MAX_WAIT cycles → mem_err=1 and the stage returns to accepting.
